// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: two-stage pipelined compare/select for unpacked FP operands with valid/ready.
// Define FP_COMPARE_REDUCE_EN to enable packet-wide MIN/MAX reduction reporting the winning index.
module fp_compare_pipe #(
  parameter int unsigned EXP_W  = 7,
  parameter int unsigned FRAC_W = 14,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_last,
  input  logic              sign_a,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [FRAC_W-1:0] frac_a,
  input  logic              sign_b,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [FRAC_W-1:0] frac_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_flag,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic [IDX_W-1:0]  out_idx
);

  typedef enum logic [2:0] {
    OP_GT, OP_GE, OP_LT, OP_LE, OP_EQ, OP_NE, OP_MIN, OP_MAX
  } op_e;

  // {gt, eq} of |a| against |b|: exponent signed first, then fraction unsigned.
  function automatic logic [1:0] mag_cmp(input logic [EXP_W-1:0] ea, input logic [FRAC_W-1:0] fa,
                                         input logic [EXP_W-1:0] eb, input logic [FRAC_W-1:0] fb);
    logic e_gt, e_eq;
    e_gt = $signed(ea) > $signed(eb);
    e_eq = (ea == eb);
    return {e_gt || (e_eq && (fa > fb)), e_eq && (fa == fb)};
  endfunction

  function automatic logic [1:0] signed_rel(input logic sa, input logic sb, input logic za,
                                            input logic zb, input logic [1:0] mag);
    logic [1:0] r;
    if (za && zb)      r = 2'b01;
    else if (za)       r = {sb, 1'b0};
    else if (zb)       r = {!sa, 1'b0};
    else if (sa != sb) r = {!sa, 1'b0};
    else if (!sa)      r = mag;
    else               r = {!(mag[1] || mag[0]), mag[0]};
    return r;
  endfunction

  function automatic logic mode_flag(input op_e op, input logic gt, input logic eq);
    logic f;
    case (op)
      OP_GT:   f = gt;
      OP_GE:   f = gt || eq;
      OP_LT:   f = !gt && !eq;
      OP_LE:   f = !gt;
      OP_EQ:   f = eq;
      OP_NE:   f = !eq;
      OP_MIN:  f = gt;
      default: f = !gt && !eq;
    endcase
    return f;
  endfunction

  logic              s1_valid_q, s1_sa_q, s1_sb_q, s1_za_q, s1_zb_q;
  op_e               s1_op_q;
  logic [1:0]        s1_mag_q;
  logic [EXP_W-1:0]  s1_ea_q, s1_eb_q;
  logic [FRAC_W-1:0] s1_fa_q, s1_fb_q;
  logic              s2_valid_q, s2_flag_q, s2_sign_q;
  logic [EXP_W-1:0]  s2_exp_q;
  logic [FRAC_W-1:0] s2_frac_q;
  logic              s2_valid_d, s2_flag_d, s2_sign_d, minmax;
  logic [EXP_W-1:0]  s2_exp_d;
  logic [FRAC_W-1:0] s2_frac_d;
  logic [1:0]        rel_ab;
  logic              s1_advance;

  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;

`ifdef FP_COMPARE_REDUCE_EN
  logic              s1_last_q, pkt_open_q, pkt_open_d, acc_sign_q, acc_sign_d, take;
  logic [EXP_W-1:0]  acc_exp_q, acc_exp_d;
  logic [FRAC_W-1:0] acc_frac_q, acc_frac_d;
  logic [IDX_W-1:0]  acc_idx_q, acc_idx_d, cnt_q, cnt_d, s2_idx_q, s2_idx_d;
  logic [1:0]        rel_acc;
`else
  logic              unused_last;
  assign unused_last = in_last;
`endif

  always_comb begin
    rel_ab     = signed_rel(s1_sa_q, s1_sb_q, s1_za_q, s1_zb_q, s1_mag_q);
    minmax     = (s1_op_q == OP_MIN) || (s1_op_q == OP_MAX);
    s2_flag_d  = mode_flag(s1_op_q, rel_ab[1], rel_ab[0]);
    s2_valid_d = s1_valid_q;
    s2_sign_d  = (minmax && s2_flag_d) ? s1_sb_q : s1_sa_q;
    s2_exp_d   = (minmax && s2_flag_d) ? s1_eb_q : s1_ea_q;
    s2_frac_d  = (minmax && s2_flag_d) ? s1_fb_q : s1_fa_q;
`ifdef FP_COMPARE_REDUCE_EN
    s2_idx_d   = '0;
    acc_sign_d = acc_sign_q;
    acc_exp_d  = acc_exp_q;
    acc_frac_d = acc_frac_q;
    acc_idx_d  = acc_idx_q;
    cnt_d      = cnt_q;
    pkt_open_d = pkt_open_q;
    take       = 1'b0;
    rel_acc    = signed_rel(s1_sa_q, acc_sign_q, s1_za_q, acc_frac_q == '0,
                            mag_cmp(s1_ea_q, s1_fa_q, acc_exp_q, acc_frac_q));
    // Strict improvement only, so ties keep the earlier element; operand b is unused here.
    if (s1_valid_q && minmax) begin
      if (!pkt_open_q)             take = 1'b1;
      else if (s1_op_q == OP_MIN)  take = !rel_acc[1] && !rel_acc[0];
      else                         take = rel_acc[1];
      if (take) begin
        acc_sign_d = s1_sa_q;
        acc_exp_d  = s1_ea_q;
        acc_frac_d = s1_fa_q;
        acc_idx_d  = pkt_open_q ? cnt_q : '0;
      end
      cnt_d      = pkt_open_q ? cnt_q + IDX_W'(1) : IDX_W'(1);
      pkt_open_d = !s1_last_q;
      s2_valid_d = s1_last_q;
      s2_flag_d  = 1'b0;
      s2_sign_d  = acc_sign_d;
      s2_exp_d   = acc_exp_d;
      s2_frac_d  = acc_frac_d;
      s2_idx_d   = acc_idx_d;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_GT;
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
      s1_za_q    <= 1'b0;
      s1_zb_q    <= 1'b0;
      s1_mag_q   <= '0;
      s1_ea_q    <= '0;
      s1_eb_q    <= '0;
      s1_fa_q    <= '0;
      s1_fb_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_flag_q  <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_frac_q  <= '0;
`ifdef FP_COMPARE_REDUCE_EN
      s1_last_q  <= 1'b0;
      s2_idx_q   <= '0;
      pkt_open_q <= 1'b0;
      acc_sign_q <= 1'b0;
      acc_exp_q  <= '0;
      acc_frac_q <= '0;
      acc_idx_q  <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_valid && in_ready) begin
        s1_op_q  <= op_e'(in_op);
        s1_sa_q  <= sign_a;
        s1_sb_q  <= sign_b;
        s1_za_q  <= (frac_a == '0);
        s1_zb_q  <= (frac_b == '0);
        s1_mag_q <= mag_cmp(exp_a, frac_a, exp_b, frac_b);
        s1_ea_q  <= exp_a;
        s1_eb_q  <= exp_b;
        s1_fa_q  <= frac_a;
        s1_fb_q  <= frac_b;
`ifdef FP_COMPARE_REDUCE_EN
        s1_last_q <= in_last;
`endif
      end
      if (s1_advance) begin
        s2_valid_q <= s2_valid_d;
        if (s2_valid_d) begin
          s2_flag_q <= s2_flag_d;
          s2_sign_q <= s2_sign_d;
          s2_exp_q  <= s2_exp_d;
          s2_frac_q <= s2_frac_d;
`ifdef FP_COMPARE_REDUCE_EN
          s2_idx_q  <= s2_idx_d;
`endif
        end
      end
`ifdef FP_COMPARE_REDUCE_EN
      if (s1_advance && s1_valid_q) begin
        pkt_open_q <= pkt_open_d;
        acc_sign_q <= acc_sign_d;
        acc_exp_q  <= acc_exp_d;
        acc_frac_q <= acc_frac_d;
        acc_idx_q  <= acc_idx_d;
        cnt_q      <= cnt_d;
      end
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign out_flag  = s2_flag_q;
  assign out_sign  = s2_sign_q;
  assign out_exp   = s2_exp_q;
  assign out_frac  = s2_frac_q;
`ifdef FP_COMPARE_REDUCE_EN
  assign out_idx   = s2_idx_q;
`else
  assign out_idx   = '0;
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Bench for fp_compare_pipe: directed mode cases, back-pressure, reset and a randomized stream
// checked against a real-valued reference model (plus the MAX reduction when it is compiled in).
module tb_fp_compare_pipe;
  localparam int unsigned EXP_W  = 7;
  localparam int unsigned FRAC_W = 14;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned N_RAND = 400;
`ifdef FP_COMPARE_REDUCE_EN
  localparam bit REDUCE = 1'b1;
`else
  localparam bit REDUCE = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]        op;
    logic              sa;
    logic [EXP_W-1:0]  ea;
    logic [FRAC_W-1:0] fa;
    logic              sb;
    logic [EXP_W-1:0]  eb;
    logic [FRAC_W-1:0] fb;
  } pair_t;

  typedef struct packed {
    logic              flag;
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
  } res_t;

  typedef struct packed {
    pair_t p;
    logic  flag;
    logic  selb;
  } drow_t;

  logic clk = 1'b0, rst;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_flag, out_sign;
  logic [2:0] in_op;
  logic sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b, out_exp;
  logic [FRAC_W-1:0] frac_a, frac_b, out_frac;
  logic [IDX_W-1:0] out_idx;

  int unsigned checks = 0, errors = 0;
  res_t exp_q[$];

  fp_compare_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_last(in_last), .sign_a(sign_a), .exp_a(exp_a), .frac_a(frac_a), .sign_b(sign_b),
    .exp_b(exp_b), .frac_b(frac_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_flag(out_flag), .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  // Real value of an operand: frac is a fixed-point number with FRAC_W-1 fraction bits.
  function automatic real fp_val(input logic s, input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    real r;
    int  ex;
    if (f == '0) return 0.0;
    r  = real'(f);
    ex = int'($signed(e)) - int'(FRAC_W - 1);
    for (int i = 0; i < ex; i++) r = r * 2.0;
    for (int i = 0; i < -ex; i++) r = r / 2.0;
    return s ? -r : r;
  endfunction

  function automatic res_t model(input pair_t p);
    real  ra, rb;
    res_t r;
    logic pick_b;
    ra = fp_val(p.sa, p.ea, p.fa);
    rb = fp_val(p.sb, p.eb, p.fb);
    pick_b = 1'b0;
    case (p.op)
      3'd0: r.flag = (ra > rb);
      3'd1: r.flag = (ra >= rb);
      3'd2: r.flag = (ra < rb);
      3'd3: r.flag = (ra <= rb);
      3'd4: r.flag = (ra == rb);
      3'd5: r.flag = (ra != rb);
      3'd6: begin pick_b = (rb < ra); r.flag = pick_b; end
      default: begin pick_b = (rb > ra); r.flag = pick_b; end
    endcase
    r.s = pick_b ? p.sb : p.sa;
    r.e = pick_b ? p.eb : p.ea;
    r.f = pick_b ? p.fb : p.fa;
    return r;
  endfunction

  function automatic logic [EXP_W+FRAC_W:0] rand_operand();
    logic s;
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] f;
    int unsigned k;
    s = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 0) e = EXP_W'($urandom);
    else e = EXP_W'($urandom_range(0, 3)) - EXP_W'(2);
    k = $urandom_range(0, 5);
    if (k == 0)      f = '0;
    else if (k == 1) f = 14'h2000;
    else if (k == 2) f = 14'h3000;
    else             f = {1'b1, (FRAC_W-1)'($urandom)};
    return {s, e, f};
  endfunction

  function automatic pair_t rand_pair();
    pair_t p;
    p.op = 3'($urandom_range(0, REDUCE ? 5 : 7));
    {p.sa, p.ea, p.fa} = rand_operand();
    {p.sb, p.eb, p.fb} = rand_operand();
    return p;
  endfunction

  task automatic apply(input pair_t p);
    in_op = p.op; sign_a = p.sa; exp_a = p.ea; frac_a = p.fa;
    sign_b = p.sb; exp_b = p.eb; frac_b = p.fb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({out_valid, out_flag, out_sign, out_exp, out_frac, out_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b flag=%b s=%b e=%h f=%h idx=%h, want all 0",
               out_valid, out_flag, out_sign, out_exp, out_frac, out_idx);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_compare_modes();
    drow_t rows[14];
    res_t  want, got;
    rows[0]  = {3'd0, 1'b0, 7'h00, 14'h3000, 1'b0, 7'h00, 14'h2800, 1'b1, 1'b0};
    rows[1]  = {3'd4, 1'b0, 7'h05, 14'h0000, 1'b1, 7'h7D, 14'h0000, 1'b1, 1'b0};
    rows[2]  = {3'd1, 1'b0, 7'h05, 14'h0000, 1'b1, 7'h7D, 14'h0000, 1'b1, 1'b0};
    rows[3]  = {3'd0, 1'b0, 7'h05, 14'h0000, 1'b1, 7'h7D, 14'h0000, 1'b0, 1'b0};
    rows[4]  = {3'd2, 1'b1, 7'h01, 14'h2000, 1'b1, 7'h00, 14'h2000, 1'b1, 1'b0};
    rows[5]  = {3'd6, 1'b1, 7'h01, 14'h2000, 1'b1, 7'h00, 14'h2000, 1'b0, 1'b0};
    rows[6]  = {3'd7, 1'b1, 7'h01, 14'h2000, 1'b1, 7'h00, 14'h2000, 1'b1, 1'b1};
    rows[7]  = {3'd3, 1'b0, 7'h05, 14'h0000, 1'b1, 7'h00, 14'h2000, 1'b0, 1'b0};
    rows[8]  = {3'd5, 1'b0, 7'h05, 14'h0000, 1'b1, 7'h7D, 14'h0000, 1'b0, 1'b0};
    rows[9]  = {3'd0, 1'b1, 7'h7D, 14'h0000, 1'b0, 7'h00, 14'h2800, 1'b0, 1'b0};
    rows[10] = {3'd0, 1'b0, 7'h00, 14'h2000, 1'b1, 7'h7D, 14'h0000, 1'b1, 1'b0};
    rows[11] = {3'd0, 1'b0, 7'h7F, 14'h2000, 1'b0, 7'h00, 14'h2000, 1'b0, 1'b0};
    rows[12] = {3'd6, 1'b0, 7'h05, 14'h0000, 1'b1, 7'h7D, 14'h0000, 1'b0, 1'b0};
    rows[13] = {3'd7, 1'b0, 7'h05, 14'h0000, 1'b1, 7'h7D, 14'h0000, 1'b0, 1'b0};
    out_ready = 1'b1;
    in_last   = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (REDUCE && rows[i].p.op >= 3'd6) continue;
      apply(rows[i].p);
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mode_in_ready row %0d: got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mode_lat1 row %0d: out_valid got %b want 0", i, out_valid); end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL mode_lat2 row %0d: out_valid got %b want 1", i, out_valid); end
      want.flag = rows[i].flag;
      want.s = rows[i].selb ? rows[i].p.sb : rows[i].p.sa;
      want.e = rows[i].selb ? rows[i].p.eb : rows[i].p.ea;
      want.f = rows[i].selb ? rows[i].p.fb : rows[i].p.fa;
      got = {out_flag, out_sign, out_exp, out_frac};
      checks++;
      if (got !== want || out_idx !== '0) begin
        errors++;
        $display("FAIL mode_result row %0d op %0d: got flag=%b s=%b e=%h f=%h idx=%h, want flag=%b s=%b e=%h f=%h idx=0",
                 i, rows[i].p.op, got.flag, got.s, got.e, got.f, out_idx, want.flag, want.s, want.e, want.f);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    pair_t pairs[8];
    res_t  want, got, held;
    int unsigned sent = 0, rcvd = 0, c = 0;
    logic stalled = 1'b0;
    for (int i = 0; i < 8; i++) pairs[i] = rand_pair();
    exp_q.delete();
    while (rcvd < 8 && c < 100) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      if (sent < 8) apply(pairs[sent]);
      #1;
      got = {out_flag, out_sign, out_exp, out_frac};
      if (c >= 3 && c <= 6) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall cycle %0d: in_ready=%b out_valid=%b, want 0 and 1", c, in_ready, out_valid);
        end
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          errors++;
          $display("FAIL b2b_hold cycle %0d: v=%b payload=%h, want v=1 payload=%h", c, out_valid, got, held);
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(model(pairs[sent])); sent++; end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: unexpected output %h, want none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL b2b_result #%0d: got %h want %h", rcvd, got, want);
          end
        end
        rcvd++;
      end
      stalled = out_valid && !out_ready;
      held = got;
      tick();
      c++;
    end
    in_valid = 1'b0;
    checks++;
    if (rcvd != 8 || sent != 8 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: sent=%0d received=%0d pending=%0d, want 8/8/0", sent, rcvd, exp_q.size());
    end
  endtask

  task automatic test_random_stream();
    pair_t cur;
    res_t  want, got, held;
    int unsigned sent = 0, rcvd = 0, c = 0;
    logic stalled = 1'b0;
    exp_q.delete();
    cur = rand_pair();
    while (rcvd < N_RAND && c < 6000) begin
      in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      apply(cur);
      #1;
      got = {out_flag, out_sign, out_exp, out_frac};
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || got !== held) begin
          errors++; $display("FAIL rand_hold cycle %0d: v=%b payload=%h, want v=1 payload=%h", c, out_valid, got, held);
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(model(cur)); sent++; cur = rand_pair(); end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra: unexpected output %h, want none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL rand_result #%0d: got %h want %h", rcvd, got, want);
          end
        end
        rcvd++;
      end
      stalled = out_valid && !out_ready;
      held = got;
      tick();
      c++;
    end
    in_valid = 1'b0;
    checks++;
    if (rcvd != N_RAND || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_count: received=%0d pending=%0d, want %0d/0", rcvd, exp_q.size(), N_RAND);
    end
  endtask

  task automatic test_reset_midflight();
    pair_t p0, p1, p2;
    res_t  want, got;
    int unsigned seen = 0;
    p0 = rand_pair(); p1 = rand_pair(); p2 = rand_pair();
    out_ready = 1'b0;
    apply(p0); in_valid = 1'b1;
    tick();
    apply(p1);
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pre: out_valid=%b in_ready=%b, want 1 and 0", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_clear: out_valid got %b want 0", out_valid); end
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_mid_ghost: %0d outputs after reset, want 0", seen); end
    apply(p2); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_lat1: out_valid got %b want 0", out_valid); end
    tick();
    #1;
    want = model(p2);
    got  = {out_flag, out_sign, out_exp, out_frac};
    checks++;
    if (out_valid !== 1'b1 || got !== want) begin
      errors++; $display("FAIL rst_mid_result: v=%b payload=%h, want v=1 payload=%h", out_valid, got, want);
    end
    tick();
  endtask

`ifdef FP_COMPARE_REDUCE_EN
  task automatic test_reduce_max();
    logic [EXP_W+FRAC_W:0] vals[5];
    logic [EXP_W+FRAC_W:0] got_v = '0;
    logic [IDX_W-1:0] got_idx = '0;
    int unsigned best = 0, seen = 0;
    vals[0] = {1'b0, 7'h01, 14'h3000};
    vals[1] = {1'b1, 7'h00, 14'h2000};
    vals[2] = {1'b0, 7'h02, 14'h3C00};
    vals[3] = {1'b0, 7'h02, 14'h3C00};
    vals[4] = {1'b0, 7'h01, 14'h2000};
    for (int i = 1; i < 5; i++)
      if (fp_val(vals[i][EXP_W+FRAC_W], vals[i][EXP_W+FRAC_W-1:FRAC_W], vals[i][FRAC_W-1:0]) >
          fp_val(vals[best][EXP_W+FRAC_W], vals[best][EXP_W+FRAC_W-1:FRAC_W], vals[best][FRAC_W-1:0]))
        best = i;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 5) begin
        in_op = 3'd7;
        {sign_a, exp_a, frac_a} = vals[i];
        {sign_b, exp_b, frac_b} = rand_operand();
        in_last  = (i == 4);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      if (out_valid) begin seen++; got_v = {out_sign, out_exp, out_frac}; got_idx = out_idx; end
      tick();
    end
    checks++;
    if (seen != 1 || got_v !== vals[best] || got_idx !== IDX_W'(best)) begin
      errors++;
      $display("FAIL reduce_max: outputs=%0d value=%h idx=%0d, want 1 output value=%h idx=%0d",
               seen, got_v, got_idx, vals[best], best);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_op = 3'd0;
    sign_a = 1'b0; exp_a = '0; frac_a = '0; sign_b = 1'b0; exp_b = '0; frac_b = '0;
    test_reset();
    test_compare_modes();
    test_back_to_back();
    test_random_stream();
    test_reset_midflight();
`ifdef FP_COMPARE_REDUCE_EN
    test_reduce_max();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
